button_debounce: RTL
====================

# button_debounce

Debounces and edge-detects one mechanical push-button for the LED pattern blocks. It synchronises the raw pad, requires a stable level for a programmable number of cycles, and produces a clean level plus one-cycle press/release strobes. It sits directly upstream of the flowing-water-lights controller; `btn_pulse` drives that block's `button` input.

## Interface
- `DEBOUNCE_CYCLES`, 2_000_000: consecutive stable cycles required to accept a level change (20 ms at 100 MHz); legal range 1 … 2^32-1.
- `LONG_CYCLES`, 100_000_000: hold time in cycles, measured from acceptance of the press, that fires `btn_long`; legal range 1 … 2^32-1.

Ports:
- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_raw`  in  1  asynchronous pad input, 1 = pressed.
- `btn_level`  out  1  debounced level.
- `btn_pulse`  out  1  one-cycle strobe on accepted press.
- `btn_release`  out  1  one-cycle strobe on accepted release.
- `btn_long`  out  1  one-cycle strobe on long press.

## Operation
- Synchroniser: two flops, `btn_raw` → `s1` → `s2`. The FSM uses only `s2`.
- Counters: 32-bit debounce counter `dcnt` and 32-bit hold counter `hcnt`.
- FSM states:
  - IDLE: `btn_level` = 0. When `s2` = 1, go to PRESS_WAIT with `dcnt` = 0.
  - PRESS_WAIT: `btn_level` = 0. When `s2` = 0, go to IDLE. Otherwise `dcnt`++. At `dcnt` == DEBOUNCE_CYCLES-1 with `s2` = 1, go to PRESSED, set `btn_pulse`, and clear `hcnt`.
  - PRESSED: `btn_level` = 1. `hcnt` increments and saturates at LONG_CYCLES. At `hcnt` == LONG_CYCLES-1, `btn_long` fires once. When `s2` = 0, go to RELEASE_WAIT with `dcnt` = 0.
  - RELEASE_WAIT: `btn_level` = 1 and `hcnt` keeps counting. When `s2` = 1, return to PRESSED; this is a bounce, so no strobe fires and `hcnt` is kept. Otherwise `dcnt`++. At `dcnt` == DEBOUNCE_CYCLES-1 with `s2` = 0, go to IDLE and set `btn_release`.
- Glitch filtering: a glitch shorter than DEBOUNCE_CYCLES in either direction produces no strobe and no level change.
- Strobe exclusivity: `btn_pulse`, `btn_release` and `btn_long` are mutually exclusive in any cycle.
- Strobe rate: `btn_pulse` fires at most once per accepted press. `btn_long` fires at most once per press, and never after `btn_release`.
- Reset: when `rst` = 1 at a clock edge, `s1`, `s2`, `dcnt`, `hcnt` and all outputs clear to 0 and the FSM goes to IDLE. This holds in any state and mid-count.
  - If `btn_raw` is held high through reset, a full debounce runs after `rst` deasserts and exactly one `btn_pulse` results.
  - `btn_release` is never emitted as a consequence of reset.

## Timing
- All outputs are registered. Reset value of every output is 0.
- Press latency: take edge 1 as the first edge that samples `btn_raw` = 1, with the input stable from then on. `btn_pulse` and `btn_level` rise after edge DEBOUNCE_CYCLES+3. `btn_pulse` is high for exactly one cycle.
- Release latency: symmetric. `btn_release` and the fall of `btn_level` occur after edge DEBOUNCE_CYCLES+3, counted from the first edge sampling 0.
- Long-press latency: `btn_long` asserts LONG_CYCLES cycles after `btn_pulse` asserts, provided the release has not been accepted before then.
- No combinational path from `btn_raw` to any output.

## Configuration
- `BTN_LONG_PRESS_EN` defined: `hcnt` and the `btn_long` logic are built as described above.
- `BTN_LONG_PRESS_EN` undefined:
  - `hcnt` is not instantiated.
  - `btn_long` is tied to 0.
  - Ports and all other behaviour are unchanged.

## Test plan
All scenarios use DEBOUNCE_CYCLES = 4 and LONG_CYCLES = 20.
- Clean press: `btn_raw` goes 0→1 and holds → `btn_pulse` = 1 for one cycle after edge 7 and `btn_level` = 1 from the same cycle; no other strobe.
- Bounce rejection: `btn_raw` pattern 1,1,0,1,1,0,1 then held high → exactly one `btn_pulse`, 7 cycles after the last 0→1 edge sample; nothing earlier.
- Release with glitch: press accepted, then `btn_raw` = 0 for 2 cycles, 1 for 1 cycle, then 0 and held → exactly one `btn_release`, with `btn_level` falling on the same cycle; no extra `btn_pulse`.
- Long press (macro defined): hold 40 cycles after `btn_pulse` → one `btn_long` exactly 20 cycles after `btn_pulse`, never repeated. With the macro undefined, `btn_long` stays 0 throughout.
- Reset mid-PRESS_WAIT and mid-PRESSED: assert `rst` for 1 cycle → all outputs 0 on the next cycle with no `btn_release`; with `btn_raw` still high, one `btn_pulse` follows 7 edges after `rst` deasserts.
- Downstream integration: connect `btn_pulse` to the lights controller's `button` input and press once → LED register loads 0x01 exactly once; no reload while the button is held.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button conditioner: two-flop synchroniser, stable-level debounce FSM, press/release/long strobes.
// Optional long-press detection is built only when BTN_LONG_PRESS_EN is defined; otherwise btn_long is 0.
module button_debounce #(
  parameter logic [31:0] DEBOUNCE_CYCLES = 32'd2_000_000,
  parameter logic [31:0] LONG_CYCLES     = 32'd100_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse,
  output logic btn_release,
  output logic btn_long
);

  localparam logic [1:0] IDLE         = 2'd0;
  localparam logic [1:0] PRESS_WAIT   = 2'd1;
  localparam logic [1:0] PRESSED      = 2'd2;
  localparam logic [1:0] RELEASE_WAIT = 2'd3;

  logic        s1_r;
  logic        s2_r;
  logic [1:0]  state_r;
  logic [1:0]  state_nx_s;
  logic [31:0] dcnt_r;
  logic [31:0] dcnt_nx_s;
  logic        level_r;
  logic        pulse_r;
  logic        release_r;
  logic        level_nx_s;
  logic        pulse_nx_s;
  logic        release_nx_s;

  // Two-flop synchroniser for the asynchronous pad
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_r <= 1'b0;
      s2_r <= 1'b0;
    end else begin
      s1_r <= btn_raw;
      s2_r <= s1_r;
    end
  end

  // Debounce next-state logic: a level is accepted only after DEBOUNCE_CYCLES stable samples
  always_comb begin
    state_nx_s   = state_r;
    dcnt_nx_s    = dcnt_r;
    pulse_nx_s   = 1'b0;
    release_nx_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (s2_r) begin
          state_nx_s = PRESS_WAIT;
          dcnt_nx_s  = 32'd0;
        end else begin
          state_nx_s = IDLE;
        end
      end
      PRESS_WAIT: begin
        if (!s2_r) begin
          state_nx_s = IDLE;
        end else if (dcnt_r == DEBOUNCE_CYCLES - 32'd1) begin
          state_nx_s = PRESSED;
          pulse_nx_s = 1'b1;
        end else begin
          dcnt_nx_s = dcnt_r + 32'd1;
        end
      end
      PRESSED: begin
        if (!s2_r) begin
          state_nx_s = RELEASE_WAIT;
          dcnt_nx_s  = 32'd0;
        end else begin
          state_nx_s = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        // A return to 1 here is contact bounce: resume PRESSED silently
        if (s2_r) begin
          state_nx_s = PRESSED;
        end else if (dcnt_r == DEBOUNCE_CYCLES - 32'd1) begin
          state_nx_s   = IDLE;
          release_nx_s = 1'b1;
        end else begin
          dcnt_nx_s = dcnt_r + 32'd1;
        end
      end
      default: begin
        state_nx_s = IDLE;
        dcnt_nx_s  = 32'd0;
      end
    endcase
    level_nx_s = (state_nx_s == PRESSED) || (state_nx_s == RELEASE_WAIT);
  end

  // FSM state, debounce counter and registered level/strobe outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      dcnt_r    <= 32'd0;
      level_r   <= 1'b0;
      pulse_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      state_r   <= state_nx_s;
      dcnt_r    <= dcnt_nx_s;
      level_r   <= level_nx_s;
      pulse_r   <= pulse_nx_s;
      release_r <= release_nx_s;
    end
  end

  assign btn_level   = level_r;
  assign btn_pulse   = pulse_r;
  assign btn_release = release_r;

`ifdef BTN_LONG_PRESS_EN
  logic [31:0] hcnt_r;
  logic [31:0] hcnt_nx_s;
  logic        long_r;
  logic        long_nx_s;
  logic        held_s;

  assign held_s = (state_r == PRESSED) || (state_r == RELEASE_WAIT);

  // Hold counter: cleared on press acceptance, saturates so btn_long fires once per press
  always_comb begin
    hcnt_nx_s = hcnt_r;
    long_nx_s = 1'b0;
    if (pulse_nx_s) begin
      hcnt_nx_s = 32'd0;
    end else if (held_s) begin
      if (hcnt_r != LONG_CYCLES) begin
        hcnt_nx_s = hcnt_r + 32'd1;
      end else begin
        hcnt_nx_s = hcnt_r;
      end
      // An accepted release on the same edge wins, keeping strobes exclusive
      if ((hcnt_r == LONG_CYCLES - 32'd1) && !release_nx_s) begin
        long_nx_s = 1'b1;
      end else begin
        long_nx_s = 1'b0;
      end
    end else begin
      hcnt_nx_s = hcnt_r;
    end
  end

  // Hold counter and registered long-press strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      hcnt_r <= 32'd0;
      long_r <= 1'b0;
    end else begin
      hcnt_r <= hcnt_nx_s;
      long_r <= long_nx_s;
    end
  end

  assign btn_long = long_r;
`else
  logic unused_long_cfg_s;
  assign unused_long_cfg_s = ^LONG_CYCLES;
  assign btn_long          = 1'b0;
`endif

endmodule
